apb_regfile: RTL and testbench



---
 rtl/apb_reg_pkg.sv | 18 +
 rtl/apb_id_rom.sv | 28 ++
 rtl/apb_regfile.sv | 77 +++++++
 tb/tb_apb_regfile.sv | 123 ++++++++++++
 4 files changed

// File: rtl/apb_reg_pkg.sv
// apb_reg_pkg: shared ID constants, region bases and bus FSM states for apb_regfile
package apb_reg_pkg;
  localparam logic [7:0] PID0 = 8'h19;
  localparam logic [7:0] PID1 = 8'hB8;
  localparam logic [7:0] PID2 = 8'h1B;
  localparam logic [7:0] PID4 = 8'h04;
  localparam logic [7:0] PID5 = 8'h00;
  localparam logic [7:0] PID6 = 8'h00;
  localparam logic [7:0] PID7 = 8'h00;
  localparam logic [7:0] CID0 = 8'h0D;
  localparam logic [7:0] CID1 = 8'hF0;
  localparam logic [7:0] CID2 = 8'h05;
  localparam logic [7:0] CID3 = 8'hB1;
  localparam logic [31:0] ID_BASE = 32'hFD0;
  localparam logic [31:0] ID_LAST = 32'hFFC;
  localparam logic [31:0] RSV_BASE = 32'hFC0;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
endpackage

// File: rtl/apb_id_rom.sv
// apb_id_rom: PrimeCell-style peripheral/component ID lookup for the 0xFC0-0xFFC window
module apb_id_rom
  import apb_reg_pkg::*;
(
  input  logic [3:0]  idx,
  input  logic [3:0]  ecorevnum,
  output logic [31:0] data
);
  // word 4..7 are PID4-7, 8..11 PID0-3, 12..15 CID0-3; 0..3 is the reserved block and reads 0
  always_comb begin
    data = '0;
    case (idx)
      4'd4:  data = {24'h0, PID4};
      4'd5:  data = {24'h0, PID5};
      4'd6:  data = {24'h0, PID6};
      4'd7:  data = {24'h0, PID7};
      4'd8:  data = {24'h0, PID0};
      4'd9:  data = {24'h0, PID1};
      4'd10: data = {24'h0, PID2};
      4'd11: data = {24'h0, ecorevnum, 4'h0};
      4'd12: data = {24'h0, CID0};
      4'd13: data = {24'h0, CID1};
      4'd14: data = {24'h0, CID2};
      4'd15: data = {24'h0, CID3};
      default: data = '0;
    endcase
  end
endmodule

// File: rtl/apb_regfile.sv
// apb_regfile: APB4 slave with byte-strobed RW words, RO masking, ID region, wait states and PSLVERR
module apb_regfile
  import apb_reg_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter int WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [3:0]            pstrb,
  input  logic [3:0]            ecorevnum,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  state_t r_state, w_state, w_next;
  logic [3:0] r_wcnt;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [31:0] w_addr, w_id_data;
  logic [DATA_WIDTH-1:0] w_reg_data;
  logic [ADDR_WIDTH-3:0] w_idx;
  logic [NUM_REGS-1:0] w_sel;
  logic w_reg, w_id, w_rsv, w_ro, w_err, w_we;
  assign w_addr = 32'(paddr) & ~32'h3;
  assign w_idx = paddr[ADDR_WIDTH-1:2];
  apb_id_rom u_rom (
    .idx       (paddr[5:2]),
    .ecorevnum (ecorevnum),
    .data      (w_id_data)
  );
  // one-hot word select, read mux and region/error decode
  always_comb begin
    w_sel = '0;
    w_reg_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_sel[i] = int'(w_idx) == i;
      w_reg_data |= w_sel[i] ? r_regs[i] : '0;
    end
    w_reg = |w_sel;
    w_ro = |(w_sel & RO_MASK);
    w_id = w_addr >= ID_BASE && w_addr <= ID_LAST;
    w_rsv = w_addr >= RSV_BASE && w_addr < ID_BASE;
    w_err = pwrite ? (!w_reg | w_ro) : !(w_reg | w_id | w_rsv);
  end
  // a setup cycle is recognised the cycle it appears on the bus, so SETUP overrides the registered phase
  always_comb begin
    w_state = (psel & !penable) ? SETUP : r_state;
    pready = !rst & (w_state == ACCESS) & psel & penable & (r_wcnt == WS);
    w_next = (w_state == SETUP || (w_state == ACCESS && psel && !pready)) ? ACCESS : IDLE;
  end
  // bus phase register
  always_ff @(posedge pclk) r_state <= rst ? IDLE : w_next;
  // wait-state counter, saturating at WAIT_STATES
  always_ff @(posedge pclk)
    if (rst || w_state == SETUP) r_wcnt <= '0;
    else if (w_state == ACCESS && r_wcnt < WS) r_wcnt <= r_wcnt + 4'd1;
  assign w_we = pready & pwrite & !w_err;
  assign pslverr = pready & w_err;
  assign prdata = (pready & !pwrite & !w_err) ? (w_reg ? w_reg_data : w_id ? w_id_data : '0) : '0;
  // register array with byte-lane writes on the completion cycle
  always_ff @(posedge pclk)
    if (rst) for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
    else if (w_we)
      for (int i = 0; i < NUM_REGS; i++)
        for (int k = 0; k < 4; k++)
          if (w_sel[i] & pstrb[k]) r_regs[i][8*k +: 8] <= pwdata[8*k +: 8];
endmodule

// File: tb/tb_apb_regfile.sv
// tb_apb_regfile: directed scoreboard bench for apb_regfile (zero-wait and three-wait instances)
module tb_apb_regfile;
  typedef struct {logic [31:0] rd; logic err; int acc;} exp_t;
  logic pclk = 0, rst = 1;
  logic psel0 = 0, psel3 = 0, penable = 0, pwrite = 0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0] pstrb = '0, ecorevnum = '0;
  logic [31:0] prdata0, prdata3;
  logic pready0, pready3, pslverr0, pslverr3;
  int errors = 0, checks = 0;
  exp_t q[$];
  always #5 pclk = ~pclk;
  apb_regfile #(.NUM_REGS(16), .WAIT_STATES(0), .RO_MASK(16'h0004), .RESET_VAL(32'hA5A5A5A5)) u0 (
    .pclk(pclk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .ecorevnum(ecorevnum), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0));
  apb_regfile #(.NUM_REGS(16), .WAIT_STATES(3)) u3 (
    .pclk(pclk), .rst(rst), .psel(psel3), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .ecorevnum(ecorevnum), .prdata(prdata3), .pready(pready3),
    .pslverr(pslverr3));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic xfer(input bit d, input bit w, input logic [11:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input logic [31:0] er, input logic ee, input int ea);
    exp_t e;
    int n;
    q.push_back('{er, ee, ea});
    @(posedge pclk); #1;
    psel0 = !d; psel3 = d; penable = 0; pwrite = w; paddr = a; pwdata = wd; pstrb = s;
    @(posedge pclk); #1;
    penable = 1;
    n = 1;
    @(negedge pclk);
    while (!(d ? pready3 : pready0) && n < 20) begin
      @(posedge pclk); #1;
      n++;
      @(negedge pclk);
    end
    e = q.pop_front();
    chk($sformatf("%s%0d@%h rdata", w ? "wr" : "rd", d ? 3 : 0, a), d ? prdata3 : prdata0, e.rd);
    chk($sformatf("%s%0d@%h pslverr", w ? "wr" : "rd", d ? 3 : 0, a), 32'(d ? pslverr3 : pslverr0), 32'(e.err));
    chk($sformatf("%s%0d@%h access_cycles", w ? "wr" : "rd", d ? 3 : 0, a), n, e.acc);
  endtask
  task automatic idle();
    @(posedge pclk); #1;
    psel0 = 0; psel3 = 0; penable = 0;
  endtask
  initial begin
    psel0 = 1; penable = 1; paddr = 12'h00C;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("reset pready", 32'(pready0), 0);
    chk("reset pslverr", 32'(pslverr0), 0);
    chk("reset prdata", prdata0, 0);
    @(posedge pclk); #1;
    rst = 0; psel0 = 0; penable = 0;
    xfer(0, 0, 12'h00C, 0, 0, 32'hA5A5A5A5, 0, 1);
    xfer(0, 1, 12'h004, 32'hFFFFFFFF, 4'hF, 0, 0, 1);
    xfer(0, 1, 12'h004, 32'h11223344, 4'h5, 0, 0, 1);
    xfer(0, 0, 12'h004, 0, 0, 32'hFF22FF44, 0, 1);
    xfer(0, 1, 12'h006, 32'h99999999, 4'h0, 0, 0, 1);
    xfer(0, 0, 12'h005, 0, 0, 32'hFF22FF44, 0, 1);
    idle();
    xfer(0, 1, 12'h008, 32'hDEADBEEF, 4'hF, 0, 1, 1);
    xfer(0, 0, 12'h008, 0, 0, 32'hA5A5A5A5, 0, 1);
    ecorevnum = 4'h7;
    xfer(0, 0, 12'hFEC, 0, 0, 32'h00000070, 0, 1);
    xfer(0, 0, 12'hFFC, 0, 0, 32'h000000B1, 0, 1);
    xfer(0, 0, 12'hFD0, 0, 0, 32'h00000004, 0, 1);
    xfer(0, 0, 12'hFE0, 0, 0, 32'h00000019, 0, 1);
    xfer(0, 1, 12'hFE0, 32'h12345678, 4'hF, 0, 1, 1);
    xfer(0, 0, 12'hFC4, 0, 0, 0, 0, 1);
    xfer(0, 1, 12'hFC0, 32'h12345678, 4'hF, 0, 1, 1);
    idle();
    xfer(0, 0, 12'h400, 0, 0, 0, 1, 1);
    xfer(0, 1, 12'h400, 32'h12345678, 4'hF, 0, 1, 1);
    xfer(0, 0, 12'h03C, 0, 0, 32'hA5A5A5A5, 0, 1);
    xfer(0, 0, 12'h040, 0, 0, 0, 1, 1);
    idle();
    xfer(1, 0, 12'h000, 0, 0, 0, 0, 4);
    idle();
    @(posedge pclk); #1;
    psel3 = 1; penable = 0; pwrite = 1; paddr = 12'h014; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1;
    @(negedge pclk);
    chk("abort acc1 pready", 32'(pready3), 0);
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("abort acc2 pready", 32'(pready3), 0);
    @(posedge pclk); #1;
    psel3 = 0; penable = 0;
    @(negedge pclk);
    chk("abort dropped pready", 32'(pready3), 0);
    xfer(1, 0, 12'h014, 0, 0, 0, 0, 4);
    xfer(1, 1, 12'h014, 32'h0BADCAFE, 4'hF, 0, 0, 4);
    xfer(1, 0, 12'h014, 0, 0, 32'h0BADCAFE, 0, 4);
    idle();
    xfer(0, 1, 12'h018, 32'h5A5A0000, 4'hC, 0, 0, 1);
    xfer(0, 0, 12'h018, 0, 0, 32'h5A5AA5A5, 0, 1);
    idle();
    @(posedge pclk); #1;
    psel0 = 1; penable = 0; pwrite = 1; paddr = 12'h018; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1; rst = 1;
    @(negedge pclk);
    chk("rst mid-access pready", 32'(pready0), 0);
    chk("rst mid-access pslverr", 32'(pslverr0), 0);
    @(posedge pclk); #1;
    rst = 0; psel0 = 0; penable = 0;
    xfer(0, 0, 12'h018, 0, 0, 32'hA5A5A5A5, 0, 1);
    xfer(0, 0, 12'h004, 0, 0, 32'hA5A5A5A5, 0, 1);
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
